// File: rtl/cmd_pkg.sv
// Shared command definitions for the command link (encoder and decoder).
// Command byte values and the UART serializer state encoding.
package cmd_pkg;

    localparam logic [7:0] CMD_SEL0 = 8'h00;
    localparam logic [7:0] CMD_SEL1 = 8'h01;
    localparam logic [7:0] CMD_SEL2 = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer; latches a byte on start and shifts it out LSB first.
// tx_o is registered so the line never glitches.
module uart_tx_core
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_byte, w_byte_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_done, w_done_nxt;
    logic          w_last;
    logic [2:0]    w_idx_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_byte  <= 8'h00;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        w_last      = (r_cnt == LAST);
        w_idx_inc   = r_idx + 3'd1;
        unique case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (start_i) begin
                    w_state_nxt = ST_START;
                    w_byte_nxt  = byte_i;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_last) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_byte[0];
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_byte[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;
    assign tx_o   = r_tx;

endmodule

// File: rtl/cmd_encoder_tx.sv
// Encodes a (fsmsel, sel) request into a command byte and sends it over UART.
// Invalid pairs are rejected with a one-cycle error pulse.
module cmd_encoder_tx
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] fsmsel_i,
    input  logic       sel_i,
    input  logic       start_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    // Returns {valid, byte}.
    function automatic logic [8:0] encode(input logic [1:0] f, input logic s);
        logic [8:0] r;
        case ({f, s})
            3'b000:  r = {1'b1, CMD_SEL0};
            3'b010:  r = {1'b1, CMD_SEL1};
            3'b101:  r = {1'b1, CMD_SEL2};
            default: r = {1'b0, 8'h00};
        endcase
        return r;
    endfunction

    logic [8:0] w_enc;
    logic       w_valid;
    logic       w_busy;
    logic       w_accept;
    logic       r_err;

    assign w_enc    = encode(fsmsel_i, sel_i);
    assign w_valid  = w_enc[8];
    assign w_accept = start_i & ~w_busy & w_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= start_i & ~w_busy & ~w_valid;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .byte_i (w_enc[7:0]),
        .start_i(w_accept),
        .busy_o (w_busy),
        .done_o (done_o),
        .tx_o   (tx_o)
    );

    assign busy_o = w_busy;
    assign err_o  = r_err;

endmodule

// File: tb/tb_cmd_encoder_tx.sv
// Directed bench for cmd_encoder_tx at CLKS_PER_BIT=4.
module tb_cmd_encoder_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] fsmsel_i;
    logic       sel_i;
    logic       start_i;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int vec = 0;
    int miss = 0;

    logic cap_tx   [0:99];
    logic cap_busy [0:99];
    logic cap_done [0:99];
    logic cap_err  [0:99];

    always #5 clk_i = ~clk_i;

    cmd_encoder_tx #(.CLKS_PER_BIT(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .fsmsel_i(fsmsel_i),
        .sel_i   (sel_i),
        .start_i (start_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    // Expected line level k cycles after the accept edge of a frame.
    function automatic logic ftx(input logic [7:0] b, input int k);
        if (k < 4) return 1'b0;
        if (k < 36) return b[3'((k - 4) / 4)];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] f, input logic s);
        fsmsel_i = f;
        sel_i    = s;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    // Record n cycles; optionally pulse start or reset in cycle inj_k / rst_k.
    task automatic capture(input int n, input int inj_k, input logic [1:0] f,
                           input logic s, input int rst_k);
        for (int k = 0; k < n; k++) begin
            cap_tx[k]   = tx_o;
            cap_busy[k] = busy_o;
            cap_done[k] = done_o;
            cap_err[k]  = err_o;
            if (k == inj_k) begin
                fsmsel_i = f;
                sel_i    = s;
                start_i  = 1'b1;
            end
            if (k == rst_k) rst_i = 1'b1;
            tick();
            start_i = 1'b0;
            rst_i   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        fsmsel_i = 2'b00;
        sel_i = 1'b0;
        repeat (3) tick();
        vec++;
        if ({tx_o, busy_o, done_o, err_o} !== 4'b1000) begin
            miss++;
            $display("FAIL reset_state: got %b want 1000",
                     {tx_o, busy_o, done_o, err_o});
        end
        rst_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            vec++;
            if ({tx_o, busy_o, done_o, err_o} !== 4'b1000) begin
                miss++;
                $display("FAIL idle k=%0d: got %b want 1000", k,
                         {tx_o, busy_o, done_o, err_o});
            end
        end
    endtask

    task automatic test_frame_02();
        int nd, nb;
        start_cmd(2'b10, 1'b1);
        capture(48, -1, 2'b00, 1'b0, -1);
        nd = 0;
        nb = 0;
        for (int k = 0; k < 48; k++) begin
            nd += int'(cap_done[k]);
            nb += int'(cap_busy[k]);
            vec++;
            if ({cap_tx[k], cap_busy[k], cap_done[k], cap_err[k]} !==
                {ftx(8'h02, k), k < 40, k == 40, 1'b0}) begin
                miss++;
                $display("FAIL frame02 k=%0d: got %b want %b", k,
                         {cap_tx[k], cap_busy[k], cap_done[k], cap_err[k]},
                         {ftx(8'h02, k), k < 40, k == 40, 1'b0});
            end
        end
        vec++;
        if (nd != 1 || nb != 40) begin
            miss++;
            $display("FAIL frame02_counts: done=%0d busy=%0d want 1/40", nd, nb);
        end
    endtask

    task automatic test_invalid();
        logic [2:0] bad [0:2];
        bad[0] = 3'b110;
        bad[1] = 3'b100;
        bad[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            start_cmd(bad[i][2:1], bad[i][0]);
            vec++;
            if ({err_o, busy_o, tx_o} !== 3'b101) begin
                miss++;
                $display("FAIL invalid_%b pulse: got %b want 101", bad[i],
                         {err_o, busy_o, tx_o});
            end
            tick();
            vec++;
            if ({err_o, busy_o, tx_o} !== 3'b001) begin
                miss++;
                $display("FAIL invalid_%b after: got %b want 001", bad[i],
                         {err_o, busy_o, tx_o});
            end
        end
    endtask

    task automatic test_busy_ignore();
        int nd;
        start_cmd(2'b01, 1'b0);
        capture(48, 9, 2'b00, 1'b0, -1);
        nd = 0;
        for (int k = 0; k < 48; k++) begin
            nd += int'(cap_done[k]);
            vec++;
            if ({cap_tx[k], cap_busy[k], cap_err[k]} !==
                {ftx(8'h01, k), k < 40, 1'b0}) begin
                miss++;
                $display("FAIL busy_ignore k=%0d: got %b want %b", k,
                         {cap_tx[k], cap_busy[k], cap_err[k]},
                         {ftx(8'h01, k), k < 40, 1'b0});
            end
        end
        vec++;
        if (nd != 1) begin
            miss++;
            $display("FAIL busy_ignore_done: got %0d want 1", nd);
        end
    endtask

    task automatic test_back_to_back();
        logic et, eb, ed;
        start_cmd(2'b01, 1'b0);
        capture(90, 40, 2'b00, 1'b0, -1);
        for (int k = 0; k < 90; k++) begin
            if (k <= 40) begin
                et = ftx(8'h01, k);
                eb = k < 40;
                ed = k == 40;
            end else begin
                et = ftx(8'h00, k - 41);
                eb = k < 81;
                ed = k == 81;
            end
            vec++;
            if ({cap_tx[k], cap_busy[k], cap_done[k]} !== {et, eb, ed}) begin
                miss++;
                $display("FAIL back_to_back k=%0d: got %b want %b", k,
                         {cap_tx[k], cap_busy[k], cap_done[k]}, {et, eb, ed});
            end
        end
    endtask

    task automatic test_mid_reset();
        start_cmd(2'b10, 1'b1);
        capture(48, -1, 2'b00, 1'b0, 17);
        for (int k = 0; k < 48; k++) begin
            vec++;
            if (k <= 17) begin
                if ({cap_tx[k], cap_busy[k], cap_done[k]} !==
                    {ftx(8'h02, k), 1'b1, 1'b0}) begin
                    miss++;
                    $display("FAIL mid_reset pre k=%0d: got %b", k,
                             {cap_tx[k], cap_busy[k], cap_done[k]});
                end
            end else if ({cap_tx[k], cap_busy[k], cap_done[k]} !== 3'b100) begin
                miss++;
                $display("FAIL mid_reset post k=%0d: got %b want 100", k,
                         {cap_tx[k], cap_busy[k], cap_done[k]});
            end
        end
        // Start together with reset must be dropped.
        rst_i = 1'b1;
        start_cmd(2'b01, 1'b0);
        rst_i = 1'b0;
        vec++;
        if ({tx_o, busy_o, err_o} !== 3'b100) begin
            miss++;
            $display("FAIL start_in_reset: got %b want 100",
                     {tx_o, busy_o, err_o});
        end
        start_cmd(2'b10, 1'b1);
        capture(48, -1, 2'b00, 1'b0, -1);
        for (int k = 0; k < 48; k++) begin
            vec++;
            if ({cap_tx[k], cap_busy[k], cap_done[k]} !==
                {ftx(8'h02, k), k < 40, k == 40}) begin
                miss++;
                $display("FAIL post_reset_frame k=%0d: got %b want %b", k,
                         {cap_tx[k], cap_busy[k], cap_done[k]},
                         {ftx(8'h02, k), k < 40, k == 40});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_02();
        test_invalid();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/cmd_encoder_tx.md
CMD_ENCODER_TX -- requirements
Module: cmd_encoder_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (minimum 2).
REQ-002 The block SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port fsmsel_i  input  2  requested FSM select to encode.
REQ-005 The block SHALL have port sel_i  input  1  requested mux select to encode.
REQ-006 The block SHALL have port start_i  input  1  one-cycle request to encode and transmit.
REQ-007 The block SHALL have port tx_o  output  1  UART serial line, 8N1, idle high.
REQ-008 The block SHALL have port busy_o  output  1  high while a frame is in progress.
REQ-009 The block SHALL have port done_o  output  1  one-cycle pulse after the stop bit completes.
REQ-010 The block SHALL have port err_o  output  1  one-cycle pulse when a start request carries an invalid pair.

Function
REQ-011 Encoding SHALL be: (fsmsel_i=2'b00, sel_i=0) -> 8'h00; (2'b01, 0) -> 8'h01; (2'b10, 1) -> 8'h02; every other pair invalid.
REQ-012 start_i high while busy_o=0 with a valid pair SHALL latch the encoded byte and set busy_o=1 on the next edge.
REQ-013 start_i high while busy_o=0 with an invalid pair SHALL raise err_o for exactly one cycle on the next edge, transmit nothing, and leave busy_o=0.
REQ-014 start_i while busy_o=1 SHALL be ignored; no err_o, no change to the latched byte, no extension of the frame.
REQ-015 Input changes after the latch edge SHALL not affect the frame in progress.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP.
  - IDLE -> START on an accepted start.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-017 tx_o SHALL be driven from a register: START drives 0, DATA drives byte bits LSB first, and STOP and IDLE drive 1.
REQ-018 Each bit SHALL last exactly CLKS_PER_BIT cycles via a bit-period counter that wraps from CLKS_PER_BIT-1 to 0; a 3-bit index SHALL count data bits 0..7.
REQ-019 tx_o SHALL fall on the same edge that busy_o rises; one frame SHALL occupy exactly 10*CLKS_PER_BIT cycles of busy_o=1.
REQ-020 On the edge that leaves STOP, busy_o SHALL go to 0 and done_o SHALL be 1 for that one cycle.
REQ-021 A start_i in the cycle where done_o=1 SHALL be accepted, giving back-to-back frames with no idle bit.
REQ-022 The counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-023 rst_i=1 at a rising edge SHALL force state IDLE, tx_o=1, busy_o=0, done_o=0, err_o=0, counters=0, and latched byte=8'h00.
REQ-024 Reset mid-frame SHALL abort the frame immediately, with tx_o high on the next edge and no done_o pulse.
REQ-025 start_i asserted together with rst_i SHALL be ignored.

Structure
REQ-026 Command byte constants (8'h00, 8'h01, 8'h02) and the FSM state encoding SHALL live in shared package cmd_pkg, which the receive-side command decoder also uses.
REQ-027 The encoder mapping SHALL be a combinational function inside cmd_encoder_tx; the serializer SHALL be sub-module uart_tx_core (byte, start, busy, done, tx) carrying CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset then idle -> tx_o=1, busy_o=0, done_o=0, and err_o=0 for 50 cycles.
REQ-029 start_i pulse with (2'b10, 1) -> tx_o low for 4 cycles, then bits 0,1,0,0,0,0,0,0 at 4 cycles each, then high for 4 cycles; busy_o high 40 cycles; done_o pulses once.
REQ-030 start_i with (2'b11, 0) and with (2'b10, 0) -> err_o one-cycle pulse each; tx_o stays 1; busy_o stays 0.
REQ-031 Send (2'b01, 0); pulse start_i again at cycle 10 of the frame with (2'b00, 0) -> byte 8'h01 sent unaltered, second request dropped, one done_o.
REQ-032 start_i with (2'b00, 0) on the done_o cycle of a prior 8'h01 frame -> second frame START begins the next edge; tx_o=0 for 4 cycles.
REQ-033 rst_i at cycle 17 of an 8'h02 frame -> tx_o=1 and busy_o=0 the next edge; no done_o; a following start transmits a clean full frame.
